// File: rtl/fifo_ctrl_if.sv
// fifo_ctrl_if: request/status bundle between a FIFO user and fifo_ctrl.
// The err signal exists only when FIFO_ERR_EN is defined.
interface fifo_ctrl_if #(
  parameter int AW = 3
);
  logic          push;
  logic          pop;
  logic [AW-1:0] addrw;
  logic [AW-1:0] addrr;
  logic [1:0]    rw;
  logic          valid_out;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
`ifdef FIFO_ERR_EN
  logic          err;
`endif

  // User side: issues requests, observes RAM control and status.
  modport master (
`ifdef FIFO_ERR_EN
    input  err,
`endif
    output push, pop,
    input  addrw, addrr, rw, valid_out, count,
    input  full, empty, almost_full, almost_empty
  );

  // Controller side.
  modport slave (
`ifdef FIFO_ERR_EN
    output err,
`endif
    input  push, pop,
    output addrw, addrr, rw, valid_out, count,
    output full, empty, almost_full, almost_empty
  );
endinterface

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer/occupancy controller for a 2**AW deep FIFO built on an
// external RAM with a registered read port. Optional sticky overflow/underflow
// flag is enabled by defining FIFO_ERR_EN.
module fifo_ctrl #(
  parameter int AW    = 3,
  parameter int AF_TH = 6,
  parameter int AE_TH = 2
) (
  input  logic         clk,
  input  logic         reset,
  fifo_ctrl_if.slave   bus
);

  localparam logic [AW:0]   LP_DEPTH = (AW+1)'(2**AW);
  localparam logic [AW:0]   LP_AF    = (AW+1)'(AF_TH);
  localparam logic [AW:0]   LP_AE    = (AW+1)'(AE_TH);
  localparam logic [AW:0]   LP_CONE  = (AW+1)'(1);
  localparam logic [AW-1:0] LP_PONE  = AW'(1);

  typedef enum logic [1:0] {ST_EMPTY, ST_PART, ST_FULL} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          r_valid;
  logic          w_full;
  logic          w_empty;
  logic          w_push_acc;
  logic          w_pop_acc;

  assign w_full  = (r_count == LP_DEPTH);
  assign w_empty = (r_count == '0);

  // Reset also gates the strobes so the RAM sees no request while it is held.
  assign w_push_acc = bus.push & ~w_full  & ~reset;
  assign w_pop_acc  = bus.pop  & ~w_empty & ~reset;

  assign bus.rw           = {w_pop_acc, w_push_acc};
  assign bus.addrw        = r_wptr;
  assign bus.addrr        = r_rptr;
  assign bus.count        = r_count;
  assign bus.valid_out    = r_valid;
  assign bus.full         = w_full;
  assign bus.empty        = w_empty;
  assign bus.almost_full  = (r_count >= LP_AF);
  assign bus.almost_empty = (r_count <= LP_AE);

  // Pointers advance (with natural wrap) only on accepted requests.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push_acc) r_wptr <= r_wptr + LP_PONE;
      if (w_pop_acc)  r_rptr <= r_rptr + LP_PONE;
    end
  end

  // Occupancy: net change of accepted push/pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else begin
      case ({w_push_acc, w_pop_acc})
        2'b10:   r_count <= r_count + LP_CONE;
        2'b01:   r_count <= r_count - LP_CONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Read data from the RAM appears one cycle after the accepted pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_valid <= 1'b0;
    else       r_valid <= w_pop_acc;
  end

  // Status state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_EMPTY;
    else       r_state <= w_state_nxt;
  end

  // Status next-state from accepted requests and current occupancy.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: if (w_push_acc) w_state_nxt = ST_PART;
      ST_PART: begin
        if (w_push_acc && !w_pop_acc && r_count == LP_DEPTH - LP_CONE)
          w_state_nxt = ST_FULL;
        else if (w_pop_acc && !w_push_acc && r_count == LP_CONE)
          w_state_nxt = ST_EMPTY;
      end
      ST_FULL:  if (w_pop_acc) w_state_nxt = ST_PART;
      default:  w_state_nxt = ST_EMPTY;
    endcase
  end

`ifdef FIFO_ERR_EN
  logic r_err;
  assign bus.err = r_err;

  // Sticky flag for any push while full or pop while empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                            r_err <= 1'b0;
    else if ((bus.push && w_full) || (bus.pop && w_empty)) r_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: directed vector table, hand sequences and random traffic for
// fifo_ctrl, checked against a queue-based FIFO model and a behavioural RAM.
module tb_fifo_ctrl;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int AF_TH = 6;
  localparam int AE_TH = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fifo_ctrl_if #(.AW(AW)) bus ();
  fifo_ctrl #(.AW(AW), .AF_TH(AF_TH), .AE_TH(AE_TH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Attached RAM with registered read port.
  logic [7:0] mem [DEPTH];
  logic [7:0] data_in;
  logic [7:0] data_out;
  always @(posedge clk) begin
    if (bus.rw[0]) mem[bus.addrw] <= data_in;
    if (bus.rw[1]) data_out <= mem[bus.addrr];
  end

  // Reference model: contents as a queue, pointers as modular counters.
  logic [7:0] q[$];
  int         m_wp, m_rp;
  logic [7:0] m_data;
  bit         m_err;
  int         n_vec = 0;
  int         n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_wp  = 0;
    m_rp  = 0;
    m_err = 0;
  endtask

  // One clock cycle: drive, check pre-edge outputs, step model, check post-edge.
  task automatic cyc(input bit p, input bit o, input logic [7:0] d, output logic [1:0] rw_seen);
    int cnt;
    bit pa, oa;
    bus.push = p;
    bus.pop  = o;
    data_in  = d;
    #1;
    cnt = q.size();
    pa  = p && (cnt < DEPTH);
    oa  = o && (cnt > 0);
    rw_seen = bus.rw;
    chk("rw",           32'(bus.rw),           32'({oa, pa}));
    chk("count",        32'(bus.count),        32'(cnt));
    chk("full",         32'(bus.full),         32'(cnt == DEPTH));
    chk("empty",        32'(bus.empty),        32'(cnt == 0));
    chk("almost_full",  32'(bus.almost_full),  32'(cnt >= AF_TH));
    chk("almost_empty", 32'(bus.almost_empty), 32'(cnt <= AE_TH));
    chk("addrw",        32'(bus.addrw),        32'(m_wp));
    chk("addrr",        32'(bus.addrr),        32'(m_rp));
    if ((p && cnt == DEPTH) || (o && cnt == 0)) m_err = 1;
    if (oa) begin
      m_data = q.pop_front();
      m_rp   = (m_rp + 1) % DEPTH;
    end
    if (pa) begin
      q.push_back(d);
      m_wp = (m_wp + 1) % DEPTH;
    end
    @(posedge clk);
    #1;
    chk("valid_out", 32'(bus.valid_out), 32'(oa));
    if (oa) chk("data_out", 32'(data_out), 32'(m_data));
`ifdef FIFO_ERR_EN
    chk("err", 32'(bus.err), 32'(m_err));
`endif
  endtask

  task automatic reset_checks();
    chk("rst_count",  32'(bus.count),        32'd0);
    chk("rst_empty",  32'(bus.empty),        32'd1);
    chk("rst_aempty", 32'(bus.almost_empty), 32'd1);
    chk("rst_full",   32'(bus.full),         32'd0);
    chk("rst_afull",  32'(bus.almost_full),  32'd0);
    chk("rst_rw",     32'(bus.rw),           32'd0);
    chk("rst_valid",  32'(bus.valid_out),    32'd0);
    chk("rst_addrw",  32'(bus.addrw),        32'd0);
    chk("rst_addrr",  32'(bus.addrr),        32'd0);
`ifdef FIFO_ERR_EN
    chk("rst_err",    32'(bus.err),          32'd0);
`endif
  endtask

  // Reset held across an edge with both requests asserted; released mid-cycle.
  task automatic do_reset();
    bus.push = 1'b1;
    bus.pop  = 1'b1;
    reset    = 1'b1;
    #1;
    reset_checks();
    @(posedge clk);
    #1;
    reset_checks();
    model_clear();
    reset = 1'b0;
  endtask

  typedef struct {
    bit         push;
    bit         pop;
    logic [1:0] rw;
    int         count;
    bit         full;
    bit         empty;
    bit         af;
    bit         ae;
  } vec_t;

  vec_t       tbl[19];
  logic [1:0] rws;

  initial begin
    tbl = '{
      '{1, 0, 2'b01, 1, 0, 0, 0, 1},
      '{1, 0, 2'b01, 2, 0, 0, 0, 1},
      '{1, 0, 2'b01, 3, 0, 0, 0, 0},
      '{1, 0, 2'b01, 4, 0, 0, 0, 0},
      '{1, 0, 2'b01, 5, 0, 0, 0, 0},
      '{1, 0, 2'b01, 6, 0, 0, 1, 0},
      '{1, 0, 2'b01, 7, 0, 0, 1, 0},
      '{1, 0, 2'b01, 8, 1, 0, 1, 0},
      '{1, 0, 2'b00, 8, 1, 0, 1, 0},
      '{0, 1, 2'b10, 7, 0, 0, 1, 0},
      '{0, 1, 2'b10, 6, 0, 0, 1, 0},
      '{0, 1, 2'b10, 5, 0, 0, 0, 0},
      '{0, 1, 2'b10, 4, 0, 0, 0, 0},
      '{0, 1, 2'b10, 3, 0, 0, 0, 0},
      '{0, 1, 2'b10, 2, 0, 0, 0, 1},
      '{0, 1, 2'b10, 1, 0, 0, 0, 1},
      '{0, 1, 2'b10, 0, 0, 1, 0, 1},
      '{0, 1, 2'b00, 0, 0, 1, 0, 1},
      '{1, 1, 2'b01, 1, 0, 0, 0, 1}
    };
    data_in  = '0;
    bus.push = 1'b0;
    bus.pop  = 1'b0;
    reset    = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
    do_reset();

    // Directed table: fill, overflow attempt, drain, underflow, simultaneous on empty.
    for (int i = 0; i < 19; i++) begin
      cyc(tbl[i].push, tbl[i].pop, 8'(i + 1), rws);
      chk("tbl_rw",    32'(rws),              32'(tbl[i].rw));
      chk("tbl_count", 32'(bus.count),        32'(tbl[i].count));
      chk("tbl_full",  32'(bus.full),         32'(tbl[i].full));
      chk("tbl_empty", 32'(bus.empty),        32'(tbl[i].empty));
      chk("tbl_af",    32'(bus.almost_full),  32'(tbl[i].af));
      chk("tbl_ae",    32'(bus.almost_empty), 32'(tbl[i].ae));
    end

    // Fill to 5, then steady push+pop so both pointers wrap.
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1, 0, 8'(8'h20 + i), rws);
    for (int i = 0; i < 10; i++) cyc(1, 1, 8'(8'h40 + i), rws);
    chk("steady_count", 32'(bus.count), 32'd5);
    chk("steady_addrw", 32'(bus.addrw), 32'd7);
    chk("steady_addrr", 32'(bus.addrr), 32'd2);
    while (q.size() > 0) cyc(0, 1, 8'h00, rws);

    // Asynchronous reset mid-burst at count 4 with a read in flight.
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1, 0, 8'(8'h60 + i), rws);
    cyc(0, 1, 8'h00, rws);
    bus.push = 1'b1;
    bus.pop  = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    reset_checks();
    model_clear();
    @(posedge clk);
    #1;
    chk("rst_hold_count", 32'(bus.count), 32'd0);
    reset = 1'b0;
    cyc(1, 0, 8'h77, rws);
    chk("first_push_count", 32'(bus.count), 32'd1);

    // Random traffic in phases of differing push/pop bias.
    for (int ph = 0; ph < 4; ph++) begin
      int pb;
      pb = (ph == 0) ? 80 : (ph == 1) ? 20 : 50;
      for (int i = 0; i < 150; i++)
        cyc($urandom_range(0, 99) < pb, $urandom_range(0, 99) < (100 - pb),
            8'($urandom), rws);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fifo_ctrl.md
FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
REQ-001 Parameter AW, default 3, address width of the attached RAM; FIFO depth SHALL be 2**AW.
REQ-002 Parameter AF_TH, default 6, almost_full threshold, in entries.
REQ-003 Parameter AE_TH, default 2, almost_empty threshold, in entries.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 push  input  1  write request; the RAM data_in bus carries the word in the same cycle.
REQ-007 pop  input  1  read request.
REQ-008 addrw  output  AW  RAM write address, equal to the write pointer.
REQ-009 addrr  output  AW  RAM read address, equal to the read pointer.
REQ-010 rw  output  2  RAM strobes: rw[0] is write enable, rw[1] is read enable.
REQ-011 valid_out  output  1  RAM data_out holds a popped word this cycle.
REQ-012 count  output  AW+1  current occupancy, range 0..2**AW.
REQ-013 full, empty, almost_full, almost_empty  output  1 each  status flags.
REQ-014 err  output  1  sticky overflow/underflow flag; present only when FIFO_ERR_EN is defined.

Function
REQ-015 push_acc SHALL be push AND NOT full; pop_acc SHALL be pop AND NOT empty; both are evaluated on pre-edge state.
REQ-016 rw SHALL be combinational {pop_acc, push_acc}, so the RAM samples the request on the same edge.
REQ-017 The write pointer SHALL increment modulo 2**AW on each push_acc, wrapping from 2**AW-1 to 0.
REQ-018 The read pointer SHALL increment modulo 2**AW on each pop_acc, with the same wrap.
REQ-019 count SHALL update as follows: +1 on push_acc only, -1 on pop_acc only, unchanged when both or neither.
REQ-020 With simultaneous push and pop while empty: the push SHALL be accepted, the pop rejected, and count becomes 1.
REQ-021 With simultaneous push and pop while full: the pop SHALL be accepted, the push rejected, and count becomes 2**AW-1.
REQ-022 With simultaneous push and pop while partially full: both SHALL be accepted and count holds.
REQ-023 valid_out SHALL be pop_acc registered, one-cycle latency, matching the RAM registered read.
REQ-024 Flags SHALL be combinational from count: empty=(count==0), full=(count==2**AW), almost_full=(count>=AF_TH), almost_empty=(count<=AE_TH).
REQ-025 Status state machine SHALL have three states: EMPTY (count 0), PART (count 1..2**AW-1), FULL (count 2**AW).
REQ-026 State transitions: EMPTY->PART on push_acc; PART->FULL on push_acc without pop_acc when count==2**AW-1; PART->EMPTY on pop_acc without push_acc when count==1; FULL->PART on pop_acc; all other cases hold state.
REQ-027 Rejected requests SHALL leave pointers, count and rw unchanged.

Reset
REQ-028 Asserting reset SHALL immediately clear the pointers, count and valid_out to 0, regardless of clk.
REQ-029 Asserting reset SHALL immediately set the state to EMPTY and clear err to 0.
REQ-030 During reset, rw SHALL be 2'b00, empty=1, almost_empty=1, full=0 and almost_full=0.
REQ-031 A reset asserted mid-operation SHALL discard all contents, with no partial pointer update on that edge.
REQ-032 The first push SHALL be accepted on the first rising edge after reset deasserts.

Configuration
REQ-033 With macro FIFO_ERR_EN defined, err SHALL set on any cycle with push while full or pop while empty, and hold until reset.
REQ-034 Without FIFO_ERR_EN, the err port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-035 Reset, then push 8 words 0x1..0x8 -> addrw steps 0..7, count=8, full=1, almost_full=1 from count 6.
REQ-036 From full, push once more -> rw=2'b00, count stays 8, err=1 (with FIFO_ERR_EN).
REQ-037 Pop 8 times -> addrr steps 0..7, valid_out one cycle after each pop, data_out 0x1..0x8 in order, empty=1 at the end.
REQ-038 Pop while empty -> rw=2'b00, count=0; push and pop together while empty -> rw=2'b01, count=1.
REQ-039 Fill to 5, then 10 cycles of simultaneous push and pop -> count stays 5, both pointers wrap past 7 to 0, data order preserved.
REQ-040 Assert reset asynchronously mid-burst at count=4 -> count=0, empty=1 and err=0 before the next clk edge.
